// File: rtl/synth_voice_pkg.sv
// Shared state encoding, register-map offsets and note range for the voice scheduler.
package synth_voice_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WR_F0,
    WR_F1,
    WR_F2,
    WR_CTL
  } state_e;

  localparam logic [7:0] FREQ_B0      = 8'd0;
  localparam logic [7:0] FREQ_B1      = 8'd1;
  localparam logic [7:0] FREQ_B2      = 8'd2;
  localparam logic [7:0] CTL          = 8'd3;
  localparam logic [7:0] CTL_GATE_ON  = 8'h01;
  localparam logic [7:0] CTL_GATE_OFF = 8'h00;
  localparam int         NUM_NOTES    = 24;

  // Chip address of a voice's first frequency byte; wraps at 256 like the chip bus.
  function automatic logic [7:0] voice_addr(input logic [7:0] base, input int v, input int stride);
    int a;
    a = int'(base) + v * stride;
    return a[7:0];
  endfunction

endpackage

// File: rtl/voice_alloc.sv
// Combinational voice resolver: finds a voice already holding the note, the lowest
// free voice, or falls back to the round-robin steal pointer.
module voice_alloc
  import synth_voice_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int VW         = 2
) (
  input  logic [NUM_VOICES-1:0]      active_i,
  input  logic [NUM_VOICES-1:0][4:0] off_i,
  input  logic [4:0]                 evOff_i,
  input  logic                       evOn_i,
  input  logic [VW-1:0]              stealPtr_i,
  output logic [VW-1:0]              v_o,
  output logic                       hit_o,
  output logic                       free_found_o,
  output logic                       steal_o
);

  logic [VW-1:0] hitV;
  logic [VW-1:0] freeV;

  // Scanning from the top down leaves the lowest matching index in place.
  always_comb begin
    hit_o        = 1'b0;
    free_found_o = 1'b0;
    hitV         = '0;
    freeV        = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (active_i[i] && (off_i[i] == evOff_i)) begin
        hit_o = 1'b1;
        hitV  = VW'(i);
      end
      if (!active_i[i]) begin
        free_found_o = 1'b1;
        freeV        = VW'(i);
      end
    end
    steal_o = evOn_i && !hit_o && !free_found_o;
    v_o     = hit_o ? hitV : (free_found_o ? freeV : stealPtr_i);
  end

endmodule

// File: rtl/voice_scheduler.sv
// Assigns key events to wavetable voices and emits the byte-wide register writes
// that program each voice's frequency word and gate.
module voice_scheduler
  import synth_voice_pkg::*;
#(
  parameter int         NUM_VOICES   = 4,
  parameter logic [7:0] VOICE_BASE   = 8'h08,
  parameter int         VOICE_STRIDE = 4
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  KeyValid,
  output logic                  KeyReady,
  input  logic [4:0]            KeyOffset,
  input  logic                  KeyOn,
  output logic [4:0]            MapOffset,
  input  logic [23:0]           MapFreq,
  output logic                  WrValid,
  input  logic                  WrReady,
  output logic [7:0]            WrAddr,
  output logic [7:0]            WrData,
  output logic [NUM_VOICES-1:0] VoiceActive,
  output logic                  Stolen
);

  localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  state_e                     state_q;
  logic [4:0]                 evOff_q;
  logic                       evOn_q;
  logic [15:0]                freqHi_q;
  logic [NUM_VOICES-1:0]      active_q;
  logic [NUM_VOICES-1:0][4:0] off_q;
  logic [VW-1:0]              stealPtr_q;
  logic [VW-1:0]              stealPtr_d;
  logic [7:0]                 base_q;
  logic [7:0]                 voiceAddr_d;
  logic                       keyReady_q;
  logic                       wrValid_q;
  logic [7:0]                 wrAddr_q;
  logic [7:0]                 wrData_q;
  logic                       stolen_q;

  logic [VW-1:0] allocV;
  logic          allocHit;
  logic          allocFree;
  logic          allocSteal;

  voice_alloc #(
    .NUM_VOICES(NUM_VOICES),
    .VW        (VW)
  ) u_alloc (
    .active_i    (active_q),
    .off_i       (off_q),
    .evOff_i     (evOff_q),
    .evOn_i      (evOn_q),
    .stealPtr_i  (stealPtr_q),
    .v_o         (allocV),
    .hit_o       (allocHit),
    .free_found_o(allocFree),
    .steal_o     (allocSteal)
  );

  always_comb begin
    stealPtr_d  = (stealPtr_q == VW'(NUM_VOICES - 1)) ? '0 : stealPtr_q + VW'(1);
    voiceAddr_d = voice_addr(VOICE_BASE, int'(allocV), VOICE_STRIDE);
  end

  // The low frequency byte goes straight out in the LOOKUP exit write, so only the
  // upper two bytes need to be kept for the following writes.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      evOff_q    <= '0;
      evOn_q     <= 1'b0;
      freqHi_q   <= '0;
      active_q   <= '0;
      off_q      <= '0;
      stealPtr_q <= '0;
      base_q     <= '0;
      keyReady_q <= 1'b1;
      wrValid_q  <= 1'b0;
      wrAddr_q   <= '0;
      wrData_q   <= '0;
      stolen_q   <= 1'b0;
    end else begin
      stolen_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (KeyValid && keyReady_q) begin
            evOff_q    <= KeyOffset;
            evOn_q     <= KeyOn;
            keyReady_q <= 1'b0;
            state_q    <= LOOKUP;
          end
        end
        LOOKUP: begin
          freqHi_q <= MapFreq[23:8];
          base_q   <= voiceAddr_d;
          if (evOn_q) begin
            if (evOff_q >= 5'(NUM_NOTES)) begin
              keyReady_q <= 1'b1;
              state_q    <= IDLE;
            end else if (allocHit || allocFree || allocSteal) begin
              active_q[allocV] <= 1'b1;
              off_q[allocV]    <= evOff_q;
              if (allocSteal) begin
                stealPtr_q <= stealPtr_d;
                stolen_q   <= 1'b1;
              end
              wrValid_q <= 1'b1;
              wrAddr_q  <= voiceAddr_d + FREQ_B0;
              wrData_q  <= MapFreq[7:0];
              state_q   <= WR_F0;
            end else begin
              keyReady_q <= 1'b1;
              state_q    <= IDLE;
            end
          end else if (allocHit) begin
            active_q[allocV] <= 1'b0;
            wrValid_q        <= 1'b1;
            wrAddr_q         <= voiceAddr_d + CTL;
            wrData_q         <= CTL_GATE_OFF;
            state_q          <= WR_CTL;
          end else begin
            keyReady_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        WR_F0: begin
          if (WrReady) begin
            wrAddr_q <= base_q + FREQ_B1;
            wrData_q <= freqHi_q[7:0];
            state_q  <= WR_F1;
          end
        end
        WR_F1: begin
          if (WrReady) begin
            wrAddr_q <= base_q + FREQ_B2;
            wrData_q <= freqHi_q[15:8];
            state_q  <= WR_F2;
          end
        end
        WR_F2: begin
          if (WrReady) begin
            wrAddr_q <= base_q + CTL;
            wrData_q <= evOn_q ? CTL_GATE_ON : CTL_GATE_OFF;
            state_q  <= WR_CTL;
          end
        end
        WR_CTL: begin
          if (WrReady) begin
            wrValid_q  <= 1'b0;
            keyReady_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: begin
          wrValid_q  <= 1'b0;
          keyReady_q <= 1'b1;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign KeyReady    = keyReady_q;
  assign MapOffset   = evOff_q;
  assign WrValid     = wrValid_q;
  assign WrAddr      = wrAddr_q;
  assign WrData      = wrData_q;
  assign VoiceActive = active_q;
  assign Stolen      = stolen_q;

endmodule

// File: tb/tb_voice_scheduler.sv
// Randomized and directed bench for voice_scheduler, checked every cycle against a
// transaction-level model of voice allocation and the expected register writes.
module tb_voice_scheduler;

  localparam int NV     = 4;
  localparam int BASE   = 8;
  localparam int STRIDE = 4;

  localparam int M_IDLE    = 0;
  localparam int M_RESOLVE = 1;
  localparam int M_WRITE   = 2;

  logic          Clk;
  logic          Reset_n;
  logic          KeyValid;
  logic          KeyReady;
  logic [4:0]    KeyOffset;
  logic          KeyOn;
  logic [4:0]    MapOffset;
  logic [23:0]   MapFreq;
  logic          WrValid;
  logic          WrReady;
  logic [7:0]    WrAddr;
  logic [7:0]    WrData;
  logic [NV-1:0] VoiceActive;
  logic          Stolen;

  int assertCount = 0;
  int failCount   = 0;
  int stolenCount = 0;
  bit randReady   = 0;
  logic [15:0] wrLog[$];

  // Reference model state
  int          phase;
  int          pendOff;
  bit          pendOn;
  int          lastOff;
  bit          mAct[NV];
  int          mOff[NV];
  int          mSp;
  bit          expStolen;
  logic [15:0] expQ[$];

  // External frequency table: two real entries, the rest arbitrary but distinct.
  function automatic logic [23:0] freqWord(input int n);
    logic [23:0] w;
    case (n)
      4:       w = 24'h01E9DB;
      9:       w = 24'h028DDF;
      default: w = {3'b000, 5'(n), 8'(n * 37 + 5), 8'(n * 11 + 3)};
    endcase
    return w;
  endfunction

  assign MapFreq = freqWord(int'(MapOffset));

  voice_scheduler #(
    .NUM_VOICES  (NV),
    .VOICE_BASE  (8'h08),
    .VOICE_STRIDE(STRIDE)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .KeyValid   (KeyValid),
    .KeyReady   (KeyReady),
    .KeyOffset  (KeyOffset),
    .KeyOn      (KeyOn),
    .MapOffset  (MapOffset),
    .MapFreq    (MapFreq),
    .WrValid    (WrValid),
    .WrReady    (WrReady),
    .WrAddr     (WrAddr),
    .WrData     (WrData),
    .VoiceActive(VoiceActive),
    .Stolen     (Stolen)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    phase     = M_IDLE;
    pendOff   = 0;
    pendOn    = 0;
    lastOff   = 0;
    mSp       = 0;
    expStolen = 0;
    expQ.delete();
    for (int i = 0; i < NV; i++) begin
      mAct[i] = 0;
      mOff[i] = 0;
    end
  endtask

  function automatic logic [31:0] activeVec();
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < NV; i++) r[i] = mAct[i];
    return r;
  endfunction

  // Advance the model across one rising edge using the inputs the DUT will see.
  task automatic modelStep();
    int          v;
    int          a;
    bit          hit;
    bit          freeFound;
    logic [23:0] w;
    expStolen = 0;
    case (phase)
      M_IDLE: begin
        if (KeyValid) begin
          pendOff = int'(KeyOffset);
          pendOn  = KeyOn;
          lastOff = pendOff;
          phase   = M_RESOLVE;
        end
      end
      M_RESOLVE: begin
        hit = 0;
        v   = 0;
        for (int i = 0; i < NV; i++) begin
          if (!hit && mAct[i] && mOff[i] == pendOff) begin
            hit = 1;
            v   = i;
          end
        end
        if (pendOn) begin
          if (pendOff >= 24) begin
            phase = M_IDLE;
          end else begin
            if (!hit) begin
              freeFound = 0;
              for (int i = 0; i < NV; i++) begin
                if (!freeFound && !mAct[i]) begin
                  freeFound = 1;
                  v         = i;
                end
              end
              if (!freeFound) begin
                v         = mSp;
                mSp       = (mSp + 1) % NV;
                expStolen = 1;
              end
            end
            mAct[v] = 1;
            mOff[v] = pendOff;
            a = (BASE + v * STRIDE) % 256;
            w = freqWord(pendOff);
            expQ.push_back({8'(a), w[7:0]});
            expQ.push_back({8'(a + 1), w[15:8]});
            expQ.push_back({8'(a + 2), w[23:16]});
            expQ.push_back({8'(a + 3), 8'h01});
            phase = M_WRITE;
          end
        end else if (hit) begin
          mAct[v] = 0;
          a = (BASE + v * STRIDE) % 256;
          expQ.push_back({8'(a + 3), 8'h00});
          phase = M_WRITE;
        end else begin
          phase = M_IDLE;
        end
      end
      default: begin
        if (WrReady) begin
          void'(expQ.pop_front());
          if (expQ.size() == 0) phase = M_IDLE;
        end
      end
    endcase
  endtask

  always @(negedge Clk) begin
    if (!Reset_n) begin
      modelReset();
      checkOutput("rst_keyready", 32'(KeyReady), 32'd1);
      checkOutput("rst_wrvalid", 32'(WrValid), 32'd0);
      checkOutput("rst_wraddr", 32'(WrAddr), 32'd0);
      checkOutput("rst_wrdata", 32'(WrData), 32'd0);
      checkOutput("rst_mapoffset", 32'(MapOffset), 32'd0);
      checkOutput("rst_active", 32'(VoiceActive), 32'd0);
      checkOutput("rst_stolen", 32'(Stolen), 32'd0);
    end else begin
      if (WrValid && WrReady) wrLog.push_back({WrAddr, WrData});
      if (Stolen) stolenCount++;
      checkOutput("keyready", 32'(KeyReady), 32'(phase == M_IDLE));
      checkOutput("wrvalid", 32'(WrValid), 32'(phase == M_WRITE));
      if (phase == M_WRITE) begin
        checkOutput("wraddr", 32'(WrAddr), 32'(expQ[0][15:8]));
        checkOutput("wrdata", 32'(WrData), 32'(expQ[0][7:0]));
      end
      checkOutput("voiceactive", 32'(VoiceActive), activeVec());
      checkOutput("stolen", 32'(Stolen), 32'(expStolen));
      checkOutput("mapoffset", 32'(MapOffset), 32'(lastOff));
      modelStep();
    end
  end

  initial begin
    forever begin
      @(posedge Clk);
      #1;
      if (randReady) WrReady = ($urandom % 4) != 0;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic doReset();
    Reset_n = 1'b0;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
  endtask

  // Holds the event until it is accepted; returns just after the accepting edge.
  task automatic applyStimulus(input int off, input bit on);
    int guard;
    bit acc;
    guard     = 0;
    acc       = 0;
    KeyOffset = 5'(off);
    KeyOn     = on;
    KeyValid  = 1'b1;
    while (!acc && guard < 500) begin
      @(negedge Clk);
      acc = KeyReady;
      @(posedge Clk);
      #1;
      guard++;
    end
    KeyValid = 1'b0;
    checkOutput("accept_reached", 32'(acc), 32'd1);
  endtask

  // Counts edges from the accepting edge up to the first edge that could accept again.
  task automatic waitIdle(output int lat);
    bit rdy;
    rdy = 0;
    lat = 1;
    while (lat < 500) begin
      @(negedge Clk);
      rdy = KeyReady;
      if (rdy) break;
      @(posedge Clk);
      lat++;
    end
    checkOutput("idle_reached", 32'(rdy), 32'd1);
    @(posedge Clk);
    #1;
  endtask

  task automatic checkFourWrites(input string name, input logic [15:0] e0, input logic [15:0] e1,
                                 input logic [15:0] e2, input logic [15:0] e3);
    checkOutput({name, "_count"}, 32'(wrLog.size()), 32'd4);
    if (wrLog.size() >= 4) begin
      checkOutput({name, "_w0"}, 32'(wrLog[0]), 32'(e0));
      checkOutput({name, "_w1"}, 32'(wrLog[1]), 32'(e1));
      checkOutput({name, "_w2"}, 32'(wrLog[2]), 32'(e2));
      checkOutput({name, "_w3"}, 32'(wrLog[3]), 32'(e3));
    end
  endtask

  initial begin
    int lat;
    int off;
    bit on;
    Reset_n   = 1'b0;
    KeyValid  = 1'b0;
    KeyOffset = '0;
    KeyOn     = 1'b0;
    WrReady   = 1'b1;
    modelReset();
    doReset();

    $display("[TB] press A4 from reset");
    wrLog.delete();
    applyStimulus(9, 1);
    waitIdle(lat);
    checkOutput("press9_latency", 32'(lat), 32'd6);
    checkFourWrites("press9", 16'h08DF, 16'h098D, 16'h0A02, 16'h0B01);
    checkOutput("press9_active", 32'(VoiceActive), 32'h1);

    $display("[TB] fill all voices and steal");
    doReset();
    stolenCount = 0;
    for (int n = 0; n < 4; n++) begin
      applyStimulus(n, 1);
      waitIdle(lat);
    end
    wrLog.delete();
    applyStimulus(4, 1);
    waitIdle(lat);
    checkFourWrites("steal", 16'h08DB, 16'h09E9, 16'h0A01, 16'h0B01);
    checkOutput("steal_pulses", 32'(stolenCount), 32'd1);
    checkOutput("steal_active", 32'(VoiceActive), 32'hF);

    $display("[TB] releases");
    wrLog.delete();
    applyStimulus(2, 0);
    waitIdle(lat);
    checkOutput("rel2_latency", 32'(lat), 32'd3);
    checkOutput("rel2_count", 32'(wrLog.size()), 32'd1);
    if (wrLog.size() >= 1) checkOutput("rel2_write", 32'(wrLog[0]), 32'h1300);
    checkOutput("rel2_active", 32'(VoiceActive), 32'hB);
    wrLog.delete();
    applyStimulus(20, 0);
    waitIdle(lat);
    checkOutput("rel20_latency", 32'(lat), 32'd2);
    checkOutput("rel20_count", 32'(wrLog.size()), 32'd0);

    $display("[TB] stall during second frequency byte");
    doReset();
    wrLog.delete();
    applyStimulus(9, 1);
    @(posedge Clk);
    #1;
    @(posedge Clk);
    #1;
    WrReady = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge Clk);
      checkOutput("stall_wrvalid", 32'(WrValid), 32'd1);
      checkOutput("stall_wraddr", 32'(WrAddr), 32'h09);
      checkOutput("stall_wrdata", 32'(WrData), 32'h8D);
      @(posedge Clk);
      #1;
    end
    WrReady = 1'b1;
    waitIdle(lat);
    checkFourWrites("stall", 16'h08DF, 16'h098D, 16'h0A02, 16'h0B01);

    $display("[TB] out-of-range press");
    wrLog.delete();
    applyStimulus(24, 1);
    waitIdle(lat);
    checkOutput("press24_latency", 32'(lat), 32'd2);
    checkOutput("press24_count", 32'(wrLog.size()), 32'd0);
    checkOutput("press24_active", 32'(VoiceActive), 32'h1);

    $display("[TB] reset in the middle of a sequence");
    doReset();
    applyStimulus(9, 1);
    repeat (3) begin
      @(posedge Clk);
      #1;
    end
    Reset_n = 1'b0;
    #1;
    checkOutput("midrst_wrvalid", 32'(WrValid), 32'd0);
    checkOutput("midrst_active", 32'(VoiceActive), 32'd0);
    @(posedge Clk);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    wrLog.delete();
    applyStimulus(5, 1);
    waitIdle(lat);
    checkFourWrites("postrst", 16'h083A, 16'h09BE, 16'h0A05, 16'h0B01);
    checkOutput("postrst_active", 32'(VoiceActive), 32'h1);

    $display("[TB] randomized traffic");
    randReady = 1;
    for (int k = 0; k < 300; k++) begin
      if ($urandom % 4 == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge Clk);
          #1;
        end
      end
      off = ($urandom % 5 == 0) ? int'($urandom_range(18, 27)) : int'($urandom_range(0, 9));
      on  = ($urandom % 3) != 0;
      applyStimulus(off, on);
    end
    randReady = 0;
    WrReady   = 1'b1;
    waitIdle(lat);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/voice_scheduler.md
Name: voice_scheduler

Overview:
- Accepts key press/release events (5-bit semitone offsets 0..23, C4..B5) and assigns each note to one of NUM_VOICES wavetable voices.
- Drives the shared frequency lookup (offset in, 24-bit frequency-register word out, combinational).
- Issues the byte-wide register-write sequence that programs the voice frequency and gate on the wavetable chip.
- Sits between the key scanner and the wavetable register-write port.

Parameters:
- NUM_VOICES, 4, number of voices; 2..8.
- VOICE_BASE, 8'h08, chip address of voice 0 frequency byte 0.
- VOICE_STRIDE, 4, address spacing between voices.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- KeyValid  in  1  key event valid.
- KeyReady  out  1  scheduler can accept an event.
- KeyOffset  in  5  semitone offset.
- KeyOn  in  1  1 = press, 0 = release.
- MapOffset  out  5  offset to the frequency lookup.
- MapFreq  in  24  frequency-register word from the lookup.
- WrValid  out  1  register write valid.
- WrReady  in  1  chip port accepts the write.
- WrAddr  out  8  register address.
- WrData  out  8  register data.
- VoiceActive  out  NUM_VOICES  per-voice gate state.
- Stolen  out  1  one-cycle pulse when a press steals an active voice.

Behaviour:
- Reset (Reset_n low, async):
  - state = IDLE; all voice entries inactive; StealPtr = 0.
  - Outputs: KeyReady = 1, WrValid = 0, WrAddr = 0, WrData = 0, MapOffset = 0, VoiceActive = 0, Stolen = 0.
  - Reset mid-sequence aborts the sequence. Remaining writes are never issued and are not resumed after reset.
- Event handshake:
  - An event is accepted on the edge where KeyValid && KeyReady.
  - KeyReady = 1 only in IDLE.
  - KeyOffset and KeyOn are latched into EvOff and EvOn at the accepting edge.
- Write handshake:
  - A write transfers on the edge where WrValid && WrReady.
  - While WrValid = 1, WrAddr and WrData are held stable.
  - WrValid never drops without a transfer, except on reset.
- MapOffset = EvOff, registered.
- FSM states: IDLE, LOOKUP, WR_F0, WR_F1, WR_F2, WR_CTL.
- IDLE: on accept go to LOOKUP.
- LOOKUP (exactly 1 cycle): latch MapFreq into FreqReg and resolve the voice v.
  - Press, EvOff >= 24: discard, no writes, go to IDLE.
  - Press, some active voice already holds EvOff (retrigger): use that voice, go to WR_F0.
  - Press, otherwise: use the lowest-index inactive voice.
  - Press, all voices active: v = StealPtr; StealPtr = (StealPtr+1) mod NUM_VOICES; Stolen pulses high during the cycle after LOOKUP.
  - Press, in all allocating cases: set Active[v] = 1 and Off[v] = EvOff at LOOKUP exit, then go to WR_F0.
  - Release, an active voice holds EvOff: clear Active[v] at LOOKUP exit and go to WR_CTL.
  - Release, no match: go to IDLE with no writes.
- Voice address: A = VOICE_BASE + v*VOICE_STRIDE, modulo 256.
- Write sequence:
  - WR_F0: address A, data FreqReg[7:0].
  - WR_F1: address A+1, data FreqReg[15:8].
  - WR_F2: address A+2, data FreqReg[23:16].
  - WR_CTL: address A+3, data 8'h01 for a press, 8'h00 for a release.
  - Each state advances only on transfer; WR_CTL returns to IDLE on transfer.
- Latency:
  - Accept at edge E. WrValid is first high after edge E+1.
  - With WrReady held at 1, a press occupies 6 cycles from accept to KeyReady = 1 again, and a release occupies 3 cycles.
- VoiceActive reflects the table and changes only at LOOKUP exit or on reset.
- Duplicate press of an already-active note: frequency and gate are rewritten; StealPtr and the allocation are unchanged.
- Only one event is in flight at a time; no queuing.

Decomposition:
- Package synth_voice_pkg holds:
  - state enum;
  - byte offsets FREQ_B0/B1/B2 = 0/1/2 and CTL = 3;
  - CTL_GATE_ON = 8'h01, CTL_GATE_OFF = 8'h00;
  - NUM_NOTES = 24.
- One sub-module, voice_alloc, is combinational. Inputs: Active, Off, EvOff, EvOn, StealPtr. Outputs: v, hit, free_found, steal.
- The FSM and write sequencer stay in voice_scheduler.

Test Plan:
- Press offset 9 (A4) from reset, WrReady = 1 → writes (08,DF), (09,8D), (0A,02), (0B,01); VoiceActive = 0001; KeyReady is low for 6 cycles.
- Press offsets 0, 1, 2, 3, then press 4 → the 5th press steals voice 0: Stolen pulses once; the next writes go to 08..0B with C4's replacement E4 bytes DB, E9, 01, then 01; VoiceActive = 1111.
- Release offset 2 while it is on voice 2 → single write (13,00); VoiceActive bit 2 clears. Release offset 20 (inactive) → no writes, KeyReady returns after 2 cycles.
- Hold WrReady = 0 for 10 cycles during WR_F1 → WrValid stays 1 and WrAddr/WrData stay at 09/8D; the sequence completes after WrReady rises.
- Press offset 24 → no writes and no VoiceActive change.
- Assert Reset_n low during WR_F2 → WrValid = 0 immediately; VoiceActive = 0; the next press is allocated to voice 0.
